// File: rtl/hazard_tracker.sv
// Hazard tracker for the 5-stage MIPS core: carries destination/Tnew through
// E/M/W, computes the D-stage stall, all forwarding selects and the HI/LO
// multiply/divide busy interlock.
module hazard_tracker #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [4:0] A3_D,
    input  logic [1:0] Tuse_rs,
    input  logic [1:0] Tuse_rt,
    input  logic [1:0] Res_D,
    input  logic [1:0] md_op_D,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic       fwd_rt_M,
    output logic       md_busy
);

    localparam int unsigned AW = 5;
    localparam int unsigned TW = 2;
    localparam int unsigned CW = 4;

    localparam logic [1:0] RES_NW  = 2'b00;
    localparam logic [1:0] RES_ALU = 2'b01;
    localparam logic [1:0] RES_DM  = 2'b10;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    // Stage registers
    logic [AW-1:0] a1_e, a2_e, a3_e;
    logic [TW-1:0] tnew_e;
    logic [1:0]    md_e;
    logic [AW-1:0] a2_m, a3_m;
    logic [TW-1:0] tnew_m;
    logic [AW-1:0] a3_w;
    logic [CW-1:0] md_cnt;

    // D-stage derived attributes
    logic [AW-1:0] a3_d_eff;
    logic [TW-1:0] tnew_d;
    logic          stall_rs, stall_rt, stall_md;

    // Tnew at entry to E from the result class; non-writers carry no destination
    always_comb begin
        tnew_d   = TW'(0);
        a3_d_eff = A3_D;
        case (Res_D)
            RES_ALU: tnew_d = TW'(1);
            RES_DM:  tnew_d = TW'(2);
            default: tnew_d = TW'(0);
        endcase
        if (Res_D == RES_NW) begin
            a3_d_eff = AW'(0);
        end
    end

    // E stage: load D attributes, or a bubble on stall/flush/reset
    always_ff @(posedge clk) begin
        if (!reset || flush || stall) begin
            a1_e   <= AW'(0);
            a2_e   <= AW'(0);
            a3_e   <= AW'(0);
            tnew_e <= TW'(0);
            md_e   <= MD_NONE;
        end else begin
            a1_e   <= A1_D;
            a2_e   <= A2_D;
            a3_e   <= a3_d_eff;
            tnew_e <= tnew_d;
            md_e   <= md_op_D;
        end
    end

    // M and W stages: Tnew counts down toward 0 as the producer advances
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            a2_m   <= AW'(0);
            a3_m   <= AW'(0);
            tnew_m <= TW'(0);
            a3_w   <= AW'(0);
        end else begin
            a2_m   <= a2_e;
            a3_m   <= a3_e;
            tnew_m <= (tnew_e != TW'(0)) ? tnew_e - TW'(1) : TW'(0);
            a3_w   <= a3_m;
        end
    end

    // HI/LO busy counter; flush does not cancel an operation already past E
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= CW'(0);
        end else if (md_e == MD_MULT) begin
            md_cnt <= CW'(MULT_CYC);
        end else if (md_e == MD_DIV) begin
            md_cnt <= CW'(DIV_CYC);
        end else if (md_cnt != CW'(0)) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

    // Stall when a pending producer cannot deliver in time, or HI/LO is in use
    always_comb begin
        stall_rs = (A1_D != AW'(0)) &&
                   (((A1_D == a3_e) && (tnew_e > Tuse_rs)) ||
                    ((A1_D == a3_m) && (tnew_m > Tuse_rs)));
        stall_rt = (A2_D != AW'(0)) &&
                   (((A2_D == a3_e) && (tnew_e > Tuse_rt)) ||
                    ((A2_D == a3_m) && (tnew_m > Tuse_rt)));
        md_busy  = (md_cnt != CW'(0));
        stall_md = (md_op_D != MD_NONE) &&
                   (md_busy || (md_e == MD_MULT) || (md_e == MD_DIV));
        stall    = stall_rs || stall_rt || stall_md;
    end

    // D-stage forwarding selects, nearest ready producer first
    always_comb begin
        fwd_rs_D = 2'b00;
        fwd_rt_D = 2'b00;
        if (A1_D != AW'(0)) begin
            if ((A1_D == a3_e) && (tnew_e == TW'(0)))      fwd_rs_D = 2'b01;
            else if ((A1_D == a3_m) && (tnew_m == TW'(0))) fwd_rs_D = 2'b10;
            else if (A1_D == a3_w)                         fwd_rs_D = 2'b11;
        end
        if (A2_D != AW'(0)) begin
            if ((A2_D == a3_e) && (tnew_e == TW'(0)))      fwd_rt_D = 2'b01;
            else if ((A2_D == a3_m) && (tnew_m == TW'(0))) fwd_rt_D = 2'b10;
            else if (A2_D == a3_w)                         fwd_rt_D = 2'b11;
        end
    end

    // E-stage and M-stage forwarding selects
    always_comb begin
        fwd_rs_E = 2'b00;
        fwd_rt_E = 2'b00;
        if (a1_e != AW'(0)) begin
            if ((a1_e == a3_m) && (tnew_m == TW'(0))) fwd_rs_E = 2'b01;
            else if (a1_e == a3_w)                    fwd_rs_E = 2'b10;
        end
        if (a2_e != AW'(0)) begin
            if ((a2_e == a3_m) && (tnew_m == TW'(0))) fwd_rt_E = 2'b01;
            else if (a2_e == a3_w)                    fwd_rt_E = 2'b10;
        end
        fwd_rt_M = (a2_m != AW'(0)) && (a2_m == a3_w);
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Scoreboard bench for hazard_tracker: each scenario queues the expected
// output vector as it drives a D-stage instruction and compares on pop.
module tb_hazard_tracker;

    typedef struct packed {
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic [1:0] trs;
        logic [1:0] trt;
        logic [1:0] res;
        logic [1:0] md;
        logic       fl;
        logic       rn;
    } stim_t;

    logic       clk;
    logic       reset;
    logic [4:0] A1_D, A2_D, A3_D;
    logic [1:0] Tuse_rs, Tuse_rt, Res_D, md_op_D;
    logic       flush;
    logic       stall;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
    logic       fwd_rt_M;
    logic       md_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] sb[$];

    hazard_tracker #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D),
        .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt),
        .Res_D(Res_D), .md_op_D(md_op_D), .flush(flush),
        .stall(stall),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E),
        .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input int a1, input int a2, input int a3,
                                 input int trs, input int trt, input int res,
                                 input int md, input int fl, input int rn);
        stim_t s;
        s.a1 = 5'(a1); s.a2 = 5'(a2); s.a3 = 5'(a3);
        s.trs = 2'(trs); s.trt = 2'(trt); s.res = 2'(res); s.md = 2'(md);
        s.fl = 1'(fl); s.rn = 1'(rn);
        return s;
    endfunction

    // Expected vector: {stall, rs_D, rt_D, rs_E, rt_E, rt_M, md_busy}
    function automatic logic [10:0] ev(input int st, input int rsd, input int rtd,
                                       input int rse, input int rte, input int rtm,
                                       input int busy);
        return {1'(st), 2'(rsd), 2'(rtd), 2'(rse), 2'(rte), 1'(rtm), 1'(busy)};
    endfunction

    function automatic stim_t nop();
        return mk(0, 0, 0, 3, 3, 0, 0, 0, 1);
    endfunction

    task automatic drive(input stim_t s);
        A1_D = s.a1; A2_D = s.a2; A3_D = s.a3;
        Tuse_rs = s.trs; Tuse_rt = s.trt; Res_D = s.res; md_op_D = s.md;
        flush = s.fl; reset = s.rn;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 3, 3, 0, 0, 0, 0));
    endtask

    task automatic test_reset();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        @(negedge clk);
        st.push_back(mk(5, 6, 7, 0, 0, 1, 3, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                         ex.push_back(ev(0,0,0,0,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL reset cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(29, 8, 8, 1, 3, 2, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(8, 8, 9, 1, 1, 1, 0, 0, 1));  ex.push_back(ev(1,0,0,0,0,0,0));
        st.push_back(mk(8, 8, 9, 1, 1, 1, 0, 0, 1));  ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                          ex.push_back(ev(0,0,0,2,2,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL load_use cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_alu_branch();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(0, 3, 3, 1, 3, 1, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(1,0,0,0,0,0,0));
        st.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(0,2,0,0,0,0,0));
        st.push_back(nop());                         ex.push_back(ev(0,0,0,2,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL alu_branch cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_jal_jr();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(0, 0, 31, 3, 3, 3, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(31, 0, 0, 0, 3, 0, 0, 0, 1)); ex.push_back(ev(0,1,0,0,0,0,0));
        st.push_back(nop());                          ex.push_back(ev(0,0,0,1,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL jal_jr cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(1, 2, 5, 1, 1, 1, 0, 0, 1));  ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(29, 5, 0, 1, 2, 0, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                          ex.push_back(ev(0,0,0,0,1,0,0));
        st.push_back(mk(5, 0, 0, 1, 3, 0, 0, 0, 1));  ex.push_back(ev(0,3,0,0,0,1,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL back_to_back cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_zero_reg();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(1, 2, 0, 1, 1, 1, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(0, 0, 7, 1, 1, 0, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL zero_reg cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_md_interlock();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(1, 2, 0, 1, 1, 0, 1, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(0, 0, 3, 3, 3, 1, 3, 0, 1)); ex.push_back(ev(1,0,0,0,0,0,0));
        for (int k = 0; k < 5; k++) begin
            st.push_back(mk(0, 0, 3, 3, 3, 1, 3, 0, 1)); ex.push_back(ev(1,0,0,0,0,0,1));
        end
        st.push_back(mk(0, 0, 3, 3, 3, 1, 3, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                         ex.push_back(ev(0,0,0,0,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL md_interlock cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(1, 2, 0, 1, 1, 0, 2, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                         ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(0, 0, 6, 3, 3, 1, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,1));
        st.push_back(mk(0, 0, 0, 3, 3, 0, 0, 0, 0)); ex.push_back(ev(0,0,0,0,0,0,1));
        st.push_back(mk(6, 6, 0, 0, 0, 0, 3, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL reset_mid_div cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_flush();
        stim_t st[$];
        logic [10:0] ex[$];
        logic [10:0] obs, expv;
        do_reset();
        st.push_back(mk(29, 8, 8, 1, 3, 2, 0, 0, 1)); ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(8, 8, 9, 1, 1, 1, 0, 1, 1));  ex.push_back(ev(1,0,0,0,0,0,0));
        st.push_back(mk(8, 8, 9, 1, 1, 1, 0, 0, 1));  ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(1, 2, 0, 1, 1, 0, 1, 0, 1));  ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(mk(0, 0, 0, 3, 3, 0, 0, 1, 1));  ex.push_back(ev(0,0,0,0,0,0,0));
        st.push_back(nop());                          ex.push_back(ev(0,0,0,0,0,0,1));
        foreach (st[i]) begin
            @(negedge clk); drive(st[i]); sb.push_back(ex[i]); #1;
            obs = {stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, md_busy};
            expv = sb.pop_front(); n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("FAIL flush cyc %0d got %b exp %b", i, obs, expv);
            end
        end
    endtask

    initial begin
        drive(mk(0, 0, 0, 3, 3, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_alu_branch();
        test_jal_jr();
        test_back_to_back();
        test_zero_reg();
        test_md_interlock();
        test_reset_mid_div();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
